// File: rtl/rv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer.
// Contents: FSM states, base opcodes, the instruction-class enum, trap causes
// and the NOP encoding that IR holds after reset.
package rv_mc_pkg;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      CLS_ILLEGAL,
      CLS_LUI,
      CLS_AUIPC,
      CLS_JAL,
      CLS_JALR,
      CLS_BRANCH,
      CLS_LOAD,
      CLS_STORE,
      CLS_OP_IMM,
      CLS_OP
   } opclass_e;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/rv_opclass_decode.sv
// Opcode classifier: ir[6:0] -> instruction class plus a legal flag.
// Purely combinational so the pipelined core can reuse it unchanged.
module rv_opclass_decode
   import rv_mc_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic [3:0] cls_o,
   output logic       legal_o
);

   // Map the base opcode to its class; anything unlisted is illegal.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      cls_o   = CLS_ILLEGAL;
      legal_o = 1'b1;
      case (opcode_i)
         OPC_LUI:    cls_o = CLS_LUI;
         OPC_AUIPC:  cls_o = CLS_AUIPC;
         OPC_JAL:    cls_o = CLS_JAL;
         OPC_JALR:   cls_o = CLS_JALR;
         OPC_BRANCH: cls_o = CLS_BRANCH;
         OPC_LOAD:   cls_o = CLS_LOAD;
         OPC_STORE:  cls_o = CLS_STORE;
         OPC_OP_IMM: cls_o = CLS_OP_IMM;
         OPC_OP:     cls_o = CLS_OP;
         default:    legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv_mc_sequencer.sv
// Multi-cycle RV32I sequencer: owns PC/IR, runs FETCH/DECODE/EXEC/MEM/WB
// with req/ack memory handshakes and traps on illegal opcodes or misaligned
// targets. All outputs decode from registered state only.
// Optional: define MC_PERF_CNT_EN to add cyc_cnt/ret_cnt performance counters.
module rv_mc_sequencer
   import rv_mc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
`ifdef MC_PERF_CNT_EN
   ,
   parameter int unsigned     CNT_W        = 32
`endif
) (
   input  logic            CLK,
   input  logic            RST,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   input  logic            br_taken,
   input  logic [XLEN-1:0] tgt_addr,
   output logic [31:0]     ir,
   output logic [XLEN-1:0] pc,
   output logic            exec_en,
   output logic            rf_we,
   output logic            retire,
   output logic            trap,
   output logic [1:0]      trap_cause
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt
`endif
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] npc_q, npc_d;
   logic [31:0]     ir_q, ir_d;
   logic [1:0]      cause_q, cause_d;

   logic [3:0]      cls_raw;
   opclass_e        cls;
   logic            opc_legal;
   logic            take_tgt;

   rv_opclass_decode u_opclass_decode (
      .opcode_i (ir_q[6:0]),
      .cls_o    (cls_raw),
      .legal_o  (opc_legal)
   );

   assign cls = opclass_e'(cls_raw);

   // Control transfers that redirect npc to the datapath target.
   assign take_tgt = (cls == CLS_JAL) || (cls == CLS_JALR) ||
                     ((cls == CLS_BRANCH) && br_taken);

   // State, PC, IR, npc and trap-cause registers with asynchronous reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VECTOR;
         npc_q   <= '0;
         ir_q    <= NOP_INSN;
         cause_q <= CAUSE_NONE;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values together.
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
         ir_q    <= ir_d;
         cause_q <= cause_d;
      end
   end

   // Next-state logic: sequence the phases and update PC/IR/npc/cause.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      npc_d   = npc_q;
      ir_d    = ir_q;
      cause_d = cause_q;
      case (state_q)
         ST_BOOT: state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (!opc_legal || (ir_q[1:0] != 2'b11)) begin
               cause_d = CAUSE_ILLEGAL;
               state_d = ST_TRAP;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (take_tgt && (tgt_addr[1:0] != 2'b00)) begin
               cause_d = CAUSE_MISALIGN;
               state_d = ST_TRAP;
            end else begin
               npc_d   = take_tgt ? tgt_addr : pc_q + XLEN'(4);
               state_d = ((cls == CLS_LOAD) || (cls == CLS_STORE)) ? ST_MEM : ST_WB;
            end
         end
         ST_MEM: begin
            if (dmem_ack) state_d = ST_WB;
         end
         ST_WB: begin
            pc_d    = npc_q;
            state_d = ST_FETCH;
         end
         ST_TRAP: begin
            pc_d    = TRAP_VECTOR;
            state_d = ST_FETCH;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   assign imem_req   = (state_q == ST_FETCH);
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == ST_MEM);
   assign dmem_we    = (state_q == ST_MEM) && (cls == CLS_STORE);
   assign exec_en    = (state_q == ST_EXEC);
   assign rf_we      = (state_q == ST_WB) && (cls != CLS_BRANCH) &&
                       (cls != CLS_STORE) && (ir_q[11:7] != 5'd0);
   assign retire     = (state_q == ST_WB);
   assign trap       = (state_q == ST_TRAP);
   assign ir         = ir_q;
   assign pc         = pc_q;
   assign trap_cause = cause_q;

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_q, ret_q;

   // Cycle and retire counters; both wrap naturally at 2^CNT_W.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (state_q != ST_BOOT) cyc_q <= cyc_q + CNT_W'(1);
         if (state_q == ST_WB)   ret_q <= ret_q + CNT_W'(1);
      end
   end

   assign cyc_cnt = cyc_q;
   assign ret_cnt = ret_q;
`endif

endmodule
